// File: rtl/fib_sched.sv
// fib_sched: two-requester job scheduler that drives an external Fibonacci
// generator and returns F(N) on a result channel.
//
// Handshakes: every valid/ready pair transfers exactly on a rising edge where
// both are high. The producer holds valid (and its payload) until it sees
// ready, and may withdraw the request at any time without side effects. A
// consumer-side ready may be asserted before, with or after valid.
module fib_sched #(
  parameter int WIDTH    = 30,
  parameter int MAX_N    = 44,
  parameter int STEP_DIV = 1
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [5:0]       req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [5:0]       req1_n,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_value,
  input  logic             rsp_ready,
  output logic             gen_clear,
  output logic             gen_en,
  input  logic [WIDTH-1:0] gen_value,
  output logic             busy,
  output logic             irq,
  output logic [2:0]       o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam int         DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [6:0] MAX_N7   = 7'(MAX_N);

  logic [2:0]       r_state;
  logic             r_last;    // id granted most recently
  logic             r_id;
  logic             r_err;
  logic [WIDTH-1:0] r_value;
  logic [5:0]       r_cnt;     // gen_en pulses still to issue
  logic [DIV_W-1:0] r_div;     // cycles until the next gen_en pulse
  logic             r_first;   // high during the first RESP cycle

  logic       w_idle;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_hs;
  logic [5:0] w_n;
  logic       w_fire;

  // Round-robin grant: a lone requester always wins, on contention the one
  // not granted last wins.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_grant0 = req0_valid && (!req1_valid || r_last);
    w_grant1 = req1_valid && (!req0_valid || !r_last);
    w_hs     = w_idle && (w_grant0 || w_grant1);
    w_n      = w_grant0 ? req0_n : req1_n;
    w_fire   = (r_state == S_STEP) && (r_div == '0);
  end

  // Job sequencing: accept, clear generator, step N times, capture, respond.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_value <= '0;
      r_cnt   <= '0;
      r_div   <= '0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_id   <= w_grant1;
            r_last <= w_grant1;
            r_cnt  <= w_n;
            if ({1'b0, w_n} > MAX_N7) begin
              // Out-of-range index: answer with an error, generator untouched.
              r_err   <= 1'b1;
              r_value <= '0;
              r_first <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          r_div   <= '0;
          r_state <= (r_cnt == 6'd0) ? S_CAPTURE : S_STEP;
        end
        S_STEP: begin
          if (w_fire) begin
            r_cnt <= r_cnt - 6'd1;
            r_div <= DIV_LAST;
            if (r_cnt == 6'd1) r_state <= S_CAPTURE;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        S_CAPTURE: begin
          r_value <= gen_value;
          r_err   <= 1'b0;
          r_first <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_first <= 1'b0;
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an aborted job shows nothing.
  always_comb begin
    req0_ready  = !reset && w_idle && w_grant0;
    req1_ready  = !reset && w_idle && w_grant1;
    rsp_valid   = !reset && (r_state == S_RESP);
    rsp_id      = !reset && r_id;
    rsp_err     = !reset && r_err;
    rsp_value   = reset ? '0 : r_value;
    gen_clear   = !reset && (r_state == S_CLEAR);
    gen_en      = !reset && w_fire;
    busy        = !reset && !w_idle;
    irq         = !reset && (r_state == S_RESP) && r_first;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: directed and random jobs against a Fibonacci reference model,
// with a behavioural generator attached to the scheduler.
module tb_fib_sched;
  localparam int W    = 30;
  localparam int MAXN = 44;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [5:0]   req0_n, req1_n;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] rsp_value;
  logic         rsp_ready;
  logic         gen_clear, gen_en;
  logic [W-1:0] gen_value;
  logic         busy, irq;
  logic [2:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  fib_sched #(.WIDTH(W), .MAX_N(MAXN), .STEP_DIV(1)) dut (
    .wb_clk_i(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_n(req0_n), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_n(req1_n), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_value(rsp_value), .rsp_ready(rsp_ready),
    .gen_clear(gen_clear), .gen_en(gen_en), .gen_value(gen_value),
    .busy(busy), .irq(irq), .o_dbg_state(dbg_state)
  );

  // behavioural generator: clear loads F(0), each enable advances one term
  longint g_a = 0;
  longint g_b = 1;
  always @(posedge clk) begin
    if (gen_clear) begin
      g_a <= 0;
      g_b <= 1;
    end else if (gen_en) begin
      g_a <= g_b;
      g_b <= g_a + g_b;
    end
  end
  always_comb gen_value = g_a[W-1:0];

  // activity monitors
  int en_cnt = 0, clr_cnt = 0, irq_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (gen_en) en_cnt++;
    if (gen_clear) clr_cnt++;
    if (irq) irq_cnt++;
    if (gen_en && gen_clear) both_cnt++;
  end

  // reference model
  function automatic longint fib_ref(input int n);
    longint a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string p);
    check({p, "_rdy0"}, req0_ready, 0);
    check({p, "_rdy1"}, req1_ready, 0);
    check({p, "_rsp_valid"}, rsp_valid, 0);
    check({p, "_rsp_id"}, rsp_id, 0);
    check({p, "_rsp_err"}, rsp_err, 0);
    check({p, "_rsp_value"}, rsp_value, 0);
    check({p, "_gen_clear"}, gen_clear, 0);
    check({p, "_gen_en"}, gen_en, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_irq"}, irq, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_rst");
  endtask

  // driver: one job from requester id, response held back for hold cycles
  task automatic run_job(input int id, input int n, input int hold, input bit probe);
    int lat, e0, c0, i0;
    bit got, exp_err;
    longint ref_v;
    logic [W-1:0] exp_v, v0;
    exp_err = (n > MAXN);
    ref_v   = exp_err ? 0 : fib_ref(n);
    exp_q.push_back(ref_v[W-1:0]);
    e0 = en_cnt; c0 = clr_cnt; i0 = irq_cnt;
    @(posedge clk); #1;
    if (id == 0) begin req0_valid = 1'b1; req0_n = 6'(n); end
    else         begin req1_valid = 1'b1; req1_n = 6'(n); end
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) got = 1;
    end
    check("grant", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0; got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else lat++;
    end
    check("rsp_seen", got, 1);
    check("latency", lat, exp_err ? 0 : n + 2);
    exp_v = exp_q.pop_front();
    check("rsp_id", rsp_id, id);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_value", rsp_value, exp_v);
    check("irq_first", irq, 1);
    check("busy_resp", busy, 1);
    v0 = rsp_value;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (probe && h == 0) req1_valid = 1'b1;
      if (probe && h == 1) req1_valid = 1'b0;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_value", rsp_value, v0);
      check("hold_irq", irq, 0);
      check("hold_rdy", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("done_busy", busy, 0);
    check("done_valid", rsp_valid, 0);
    check("en_pulses", en_cnt - e0, exp_err ? 0 : n);
    check("clr_pulses", clr_cnt - c0, exp_err ? 0 : 1);
    check("irq_pulses", irq_cnt - i0, 1);
    check("no_overlap", both_cnt, 0);
  endtask

  // both requesters held valid: grants must alternate starting with req0
  task automatic rr_test();
    bit got;
    int exp_g = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_n = 6'd5;
    req1_valid = 1'b1; req1_n = 6'd5;
    rsp_ready  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1;
      end
      check("rr_grant_seen", got, 1);
      check("rr_grant", {req1_ready, req0_ready}, (exp_g == 0) ? 2'b01 : 2'b10);
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (rsp_valid) got = 1;
      end
      check("rr_rsp_seen", got, 1);
      check("rr_id", rsp_id, exp_g);
      check("rr_value", rsp_value, fib_ref(5));
      exp_g = 1 - exp_g;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int i0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = '0; req1_n = '0;
    rsp_ready = 1'b0;
    do_reset();

    run_job(0, 10, 0, 0);
    run_job(0, 0, 0, 0);
    run_job(1, 1, 0, 0);
    run_job(0, 44, 0, 0);
    run_job(1, 45, 0, 0);
    run_job(0, 7, 5, 1);

    do_reset();
    rr_test();

    // abort a job mid-STEP
    do_reset();
    i0 = irq_cnt;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_n = 6'd20;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_in_step", gen_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("abort_during");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("abort_after");
    repeat (3) @(negedge clk);
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_no_irq", irq_cnt - i0, 0);
    run_job(0, 3, 0, 0);

    for (int r = 0; r < 12; r++)
      run_job($urandom_range(0, 1), $urandom_range(0, 50), $urandom_range(0, 3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_sched.md
FIB_SCHED -- requirements
Module: fib_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 30, generator value width.
REQ-002 SHALL have parameter MAX_N, default 44, largest term index representable in WIDTH bits.
REQ-003 SHALL have parameter STEP_DIV, default 1, wb_clk_i cycles per generator step (>=1).
REQ-004 SHALL have port wb_clk_i  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1 each  job request pending.
REQ-007 SHALL have ports req0_n/req1_n  input  6 each  requested term index N.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-009 SHALL have ports rsp_valid output 1, rsp_id output 1, rsp_err output 1, rsp_value output WIDTH, rsp_ready input 1: result channel.
REQ-010 SHALL have ports gen_clear output 1, gen_en output 1, gen_value input WIDTH: generator control; gen_clear loads F(0)=0, each gen_en cycle advances one term, gen_value valid the cycle after.
REQ-011 SHALL have ports busy output 1 (state != IDLE) and irq output 1 (completion pulse).

Function
REQ-012 SHALL implement states IDLE, CLEAR, STEP, CAPTURE, RESP.
REQ-013 IDLE: reqX_ready SHALL be combinational, asserted only for the granted requester and only in IDLE; handshake = valid && ready.
REQ-014 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; single valid requester always granted.
REQ-015 On handshake SHALL latch N and id (0/1) and leave IDLE next cycle.
REQ-016 If latched N > MAX_N SHALL go directly to RESP with rsp_err=1, rsp_value=0; gen_clear and gen_en SHALL stay low.
REQ-017 Else CLEAR SHALL assert gen_clear for exactly one cycle, then STEP if N>0, CAPTURE if N=0.
REQ-018 STEP SHALL issue exactly N single-cycle gen_en pulses, one every STEP_DIV cycles, using a 6-bit down-counter; after the last pulse go to CAPTURE.
REQ-019 CAPTURE SHALL register gen_value into rsp_value, rsp_err=0, then go to RESP.
REQ-020 RESP SHALL hold rsp_valid=1 with rsp_id/rsp_err/rsp_value stable until rsp_valid && rsp_ready, then return to IDLE next cycle.
REQ-021 irq SHALL pulse high for exactly one cycle, the first cycle of RESP.
REQ-022 Latency with STEP_DIV=1: handshake at cycle T -> rsp_valid first high at T+3+N; error jobs -> T+1.
REQ-023 Requests SHALL NOT be accepted while busy; a requester dropping valid before ready SHALL have no effect.
REQ-024 gen_clear and gen_en SHALL never be high in the same cycle.

Reset
REQ-025 During and after reset: state IDLE, all outputs 0 (ready, rsp_*, gen_clear, gen_en, busy, irq), last-grant = 1 so req0 wins first contention.
REQ-026 Reset asserted in any state SHALL abort the job without response or irq.

Verification (bench supplies a behavioural generator per REQ-010)
- req0 N=10 at T, rsp_ready=1 -> gen_en exactly 10 pulses, rsp_valid at T+13, value 55, id 0, err 0, irq one cycle.
- N=0, N=1, N=44 in turn -> values 0, 1, 701408733, err 0.
- req1 N=45 -> rsp_err=1, value 0, no gen_clear/gen_en, rsp_valid at T+1.
- after reset both valid N=5 continuously -> grants alternate 0,1,0,1; values 5 each.
- rsp_ready low 5 cycles in RESP -> rsp_valid/value stable, reqX_ready low, irq only once.
- reset in STEP with N=20 -> next cycle all outputs 0, busy 0; new req0 N=3 -> value 2.
